pb_conditioner: RTL and testbench
=================================

// Module: pb_conditioner
// PURPOSE
//  Front end for the pattern sequencer's step buttons. Takes the two raw active-low board keys
//  (up/down), synchronises and debounces each one, and emits single-cycle step pulses
//  pb_seq_up / pb_seq_dn in the clk_50 domain, with optional hold-to-repeat. The sequencer
//  consumes these pulses as its only step commands; it never sees raw key levels.
// PARAMETERS
//  DEBOUNCE_CYC   1_000_000   cycles a synced level must differ from the stable level before it is accepted (20 ms @ 50 MHz); >=2
//  REPEAT_EN      1           1 = hold-to-repeat enabled, 0 = exactly one pulse per press
//  REPEAT_DELAY   25_000_000  cycles from press acceptance to first repeat pulse (500 ms)
//  REPEAT_PERIOD  5_000_000   cycles between later repeat pulses (100 ms); >=1
// PORTS
//  clk_50       in   1  50 MHz system clock; all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  pb_up_n      in   1  raw UP key, asynchronous, 0 = pressed
//  pb_dn_n      in   1  raw DOWN key, asynchronous, 0 = pressed
//  pb_seq_up    out  1  one-cycle step-up pulse to the sequencer
//  pb_seq_dn    out  1  one-cycle step-down pulse to the sequencer
//  pb_up_held   out  1  debounced UP level, 1 = pressed
//  pb_dn_held   out  1  debounced DOWN level, 1 = pressed
// BEHAVIOUR
//  Reset: sync flops = 1 (released), stable = released, all counters 0; pb_seq_up,
//   pb_seq_dn, pb_up_held, pb_dn_held = 0. Applies on any edge, mid-debounce or mid-hold.
//  Sync: 2-flop chain per key; s2 = synced level; no other logic reads raw inputs.
//  Debounce: per key, cnt clears whenever s2 == stable. Otherwise cnt increments; when
//   cnt == DEBOUNCE_CYC-1 and still mismatched, stable <= s2 and cnt <= 0. Any bounce back
//   before that clears cnt, so glitches shorter than DEBOUNCE_CYC are never accepted.
//  Latency: raw press at edge 0 -> s2 at edge 2 -> stable flips at edge DEBOUNCE_CYC+2
//   -> press pulse high for the one cycle after edge DEBOUNCE_CYC+3. Release produces no pulse.
//  Hold FSM per key: IDLE -> (press accepted) FIRST, pulse; FIRST counts REPEAT_DELAY cycles
//   -> REPEAT, pulse; REPEAT pulses every REPEAT_PERIOD cycles. Release from any state -> IDLE
//   at once, counter cleared. REPEAT_EN=0: FIRST never leaves FIRST until release.
//   Hold counter is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits and never wraps.
//  Arbitration: a key's pulse is raw_pulse & ~other_held. If both raw pulses fire in the
//   same cycle, both are dropped. While both keys are held, neither key repeats.
//   pb_seq_up and pb_seq_dn are never high together.
//  A key held through reset deassert debounces as a new press: one pulse at DEBOUNCE_CYC+3
//   edges after reset falls.
//  All outputs are registered. No combinational path from input to output.
// STRUCTURE
//  pb_pkg: state encoding typedef (IDLE/FIRST/REPEAT) and default timing constants
//   for 50 MHz.
//  Sub-module pb_debounce_ch: sync + debounce + hold FSM for one key. It outputs held and
//   raw_pulse and is instantiated twice. The top level does the arbitration and the
//   output registers.
// TESTING (bench params: DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Clean press: pb_up_n 1->0 at edge 0 and held -> pb_seq_up high only in the cycle after
//   edge 7; pb_up_held=1 from edge 7; pb_seq_dn stays 0.
//  Bounce: pb_dn_n toggled every 2 cycles for 20 cycles, then released -> no pulse,
//   pb_dn_held stays 0.
//  Repeat: UP held 40 cycles with REPEAT_EN=1 -> pulses at 7, 17, 20, 23, ... (+1 cycle each);
//   with REPEAT_EN=0 -> single pulse at 7 only.
//  Simultaneous: both keys fall at the same edge -> no pulse on either output; both held=1.
//   Release UP -> still no DOWN pulse or repeat.
//  Reset mid-hold: UP held, reset pulsed for 1 cycle at edge 15 -> all outputs 0 at edge 16.
//   Key still low -> exactly one new pulse DEBOUNCE_CYC+3 edges after reset falls.
//  Exclusion check: assertion !(pb_seq_up & pb_seq_dn) holds over a 10k-cycle random press run.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types and 50 MHz timing defaults for the step-button conditioner.
package pb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      REPEAT = 2'd2
   } hold_state_e;

   localparam int unsigned DEBOUNCE_CYC_DEF  = 1_000_000;
   localparam int unsigned REPEAT_DELAY_DEF  = 25_000_000;
   localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;

   function automatic int hold_cnt_w(input int unsigned delay, input int unsigned period);
      int unsigned longest;
      longest = (delay > period) ? delay : period;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter and hold-to-repeat FSM.
//  state  | meaning
//  IDLE   | key released (debounced), no pulses
//  FIRST  | press accepted, counting the initial repeat delay
//  REPEAT | held past the delay, pulsing every repeat period
module pb_debounce_ch
   import pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk_50,
   input  logic reset,
   input  logic key_n,
   input  logic other_held,
   output logic held,
   output logic raw_pulse
);

   localparam int DCW = $clog2(DEBOUNCE_CYC);
   localparam int HCW = hold_cnt_w(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYC - 1);
   localparam logic [HCW-1:0] RD_LAST = HCW'(REPEAT_DELAY - 1);
   localparam logic [HCW-1:0] RP_LAST = HCW'(REPEAT_PERIOD - 1);

   logic           s1_q, s1_d;
   logic           s2_q, s2_d;
   logic           stable_n_q, stable_n_d;
   logic [DCW-1:0] db_cnt_q, db_cnt_d;
   hold_state_e    state_q, state_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
   logic           pulse_q, pulse_d;
   logic           lock_q, lock_d;
   logic           mismatch;
   logic           accept;

   always_comb begin
      s1_d       = key_n;
      s2_d       = s1_q;
      mismatch   = (s2_q != stable_n_q);
      accept     = mismatch && (db_cnt_q == DB_LAST);
      stable_n_d = accept ? s2_q : stable_n_q;
      db_cnt_d   = (mismatch && !accept) ? db_cnt_q + DCW'(1) : '0;

      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      pulse_d    = 1'b0;
      lock_d     = lock_q;

      if (accept && s2_q) begin
         state_d    = IDLE;
         hold_cnt_d = '0;
         lock_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && !s2_q) begin
                  state_d    = FIRST;
                  hold_cnt_d = '0;
                  pulse_d    = 1'b1;
               end
            end
            FIRST: begin
               if (REPEAT_EN) begin
                  if (hold_cnt_q == RD_LAST) begin
                     state_d    = REPEAT;
                     hold_cnt_d = '0;
                     pulse_d    = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HCW'(1);
                  end
               end
            end
            REPEAT: begin
               if (hold_cnt_q == RP_LAST) begin
                  hold_cnt_d = '0;
                  pulse_d    = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + HCW'(1);
               end
            end
            default: begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end
         endcase
         // a chord cancels this key's pulses until it is released
         if ((state_q != IDLE) && other_held) lock_d = 1'b1;
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         stable_n_q <= 1'b1;
         db_cnt_q   <= '0;
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         pulse_q    <= 1'b0;
         lock_q     <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         stable_n_q <= stable_n_d;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pulse_q    <= pulse_d;
         lock_q     <= lock_d;
      end
   end

   assign held      = ~stable_n_q;
   assign raw_pulse = pulse_q & ~lock_q;

endmodule

// File: rtl/pb_conditioner.sv
// Step-button front end: two key channels, cross-key arbitration and registered outputs.
module pb_conditioner
   import pb_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk_50,
   input  logic reset,
   input  logic pb_up_n,
   input  logic pb_dn_n,
   output logic pb_seq_up,
   output logic pb_seq_dn,
   output logic pb_up_held,
   output logic pb_dn_held
);

   logic up_held, dn_held;
   logic up_raw, dn_raw;
   logic seq_up_q, seq_up_d;
   logic seq_dn_q, seq_dn_d;
   logic up_held_q, up_held_d;
   logic dn_held_q, dn_held_d;

   pb_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_up (
      .clk_50    (clk_50),
      .reset     (reset),
      .key_n     (pb_up_n),
      .other_held(dn_held),
      .held      (up_held),
      .raw_pulse (up_raw)
   );

   pb_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_dn (
      .clk_50    (clk_50),
      .reset     (reset),
      .key_n     (pb_dn_n),
      .other_held(up_held),
      .held      (dn_held),
      .raw_pulse (dn_raw)
   );

   // a raw pulse always implies its own key is held, so the two can never coincide
   always_comb begin
      seq_up_d  = up_raw & ~dn_held;
      seq_dn_d  = dn_raw & ~up_held;
      up_held_d = up_held;
      dn_held_d = dn_held;
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         seq_up_q  <= 1'b0;
         seq_dn_q  <= 1'b0;
         up_held_q <= 1'b0;
         dn_held_q <= 1'b0;
      end else begin
         seq_up_q  <= seq_up_d;
         seq_dn_q  <= seq_dn_d;
         up_held_q <= up_held_d;
         dn_held_q <= dn_held_d;
      end
   end

   assign pb_seq_up  = seq_up_q;
   assign pb_seq_dn  = seq_dn_q;
   assign pb_up_held = up_held_q;
   assign pb_dn_held = dn_held_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus a random press run against a reference model.
module tb_pb_conditioner;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;

   logic       clk_50  = 1'b0;
   logic       reset   = 1'b1;
   logic       pb_up_n = 1'b1;
   logic       pb_dn_n = 1'b1;
   logic [1:0] seq_up, seq_dn, up_held, dn_held;

   pb_conditioner #(.DEBOUNCE_CYC(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
      .clk_50(clk_50), .reset(reset), .pb_up_n(pb_up_n), .pb_dn_n(pb_dn_n),
      .pb_seq_up(seq_up[0]), .pb_seq_dn(seq_dn[0]), .pb_up_held(up_held[0]), .pb_dn_held(dn_held[0]));

   pb_conditioner #(.DEBOUNCE_CYC(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_one (
      .clk_50(clk_50), .reset(reset), .pb_up_n(pb_up_n), .pb_dn_n(pb_dn_n),
      .pb_seq_up(seq_up[1]), .pb_seq_dn(seq_dn[1]), .pb_up_held(up_held[1]), .pb_dn_held(dn_held[1]));

   always #10 clk_50 = ~clk_50;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int e0       = 0;
   bit chk_en   = 1'b0;

   int lq_up0[$], lq_up1[$], lq_dn0[$], lq_dn1[$];
   bit dn_held_seen;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic cmp_log(input string tag, input int got[$], input int want[$]);
      chk({tag, "_count"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got[i], want[i]);
   endtask

   task automatic clear_logs();
      lq_up0.delete(); lq_up1.delete(); lq_dn0.delete(); lq_dn1.delete();
      dn_held_seen = 1'b0;
   endtask

   task automatic to_rel(input int r);
      while (cyc < e0 + r) @(posedge clk_50);
      #1;
   endtask

   // Reference model: a key is accepted once the synchronised level has differed
   // from the stable level for DEB straight samples; pulses follow from the time
   // since acceptance; any overlap with the other key held cancels pulses.
   bit exp_seq [2][2];
   bit exp_held[2][2];
   bit pend    [2][2];
   bit ren     [2] = '{1'b1, 1'b0};
   bit m_prs   [2];
   bit m_last  [2];
   bit ovl     [2];
   int acc     [2];
   bit win     [2][DEB];
   int win_n   [2];

   initial begin
      bit pin[2];
      bit s2, lvl, flip, fire;
      int age;
      forever begin
         @(posedge clk_50);
         cyc++;
         pin[0] = pb_up_n;
         pin[1] = pb_dn_n;
         if (reset) begin
            for (int k = 0; k < 2; k++) begin
               m_last[k]         = 1'b1;
               win_n[k]          = 1;
               win[k][DEB-1]     = 1'b1;
               m_prs[k]          = 1'b0;
               ovl[k]            = 1'b0;
               for (int i = 0; i < 2; i++) begin
                  exp_seq[i][k]  = 1'b0;
                  exp_held[i][k] = 1'b0;
                  pend[i][k]     = 1'b0;
               end
            end
         end else begin
            for (int i = 0; i < 2; i++)
               for (int k = 0; k < 2; k++) begin
                  exp_seq[i][k]  = pend[i][k];
                  exp_held[i][k] = m_prs[k];
               end
            for (int k = 0; k < 2; k++) begin
               s2        = m_last[k];
               m_last[k] = pin[k];
               lvl       = m_prs[k] ? 1'b0 : 1'b1;
               flip      = (win_n[k] == DEB);
               for (int j = 0; j < DEB; j++)
                  if (win[k][j] == lvl) flip = 1'b0;
               if (flip) begin
                  m_prs[k] = !m_prs[k];
                  if (m_prs[k]) acc[k] = cyc;
               end
               for (int j = 0; j < DEB - 1; j++) win[k][j] = win[k][j+1];
               win[k][DEB-1] = s2;
               if (win_n[k] < DEB) win_n[k]++;
            end
            for (int k = 0; k < 2; k++) begin
               if (!m_prs[k]) ovl[k] = 1'b0;
               else if (m_prs[1-k]) ovl[k] = 1'b1;
            end
            for (int i = 0; i < 2; i++)
               for (int k = 0; k < 2; k++) begin
                  age  = cyc - acc[k];
                  fire = m_prs[k] && (age == 0 || (ren[i] && age >= RD && ((age - RD) % RP) == 0));
                  pend[i][k] = fire && !ovl[k];
               end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_50);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("seq_up%0d", i),  seq_up[i],  exp_seq[i][0]);
               chk($sformatf("seq_dn%0d", i),  seq_dn[i],  exp_seq[i][1]);
               chk($sformatf("up_held%0d", i), up_held[i], exp_held[i][0]);
               chk($sformatf("dn_held%0d", i), dn_held[i], exp_held[i][1]);
               chk($sformatf("excl%0d", i),    seq_up[i] & seq_dn[i], 1'b0);
            end
            if (seq_up[0] === 1'b1) lq_up0.push_back(cyc - e0);
            if (seq_up[1] === 1'b1) lq_up1.push_back(cyc - e0);
            if (seq_dn[0] === 1'b1) lq_dn0.push_back(cyc - e0);
            if (seq_dn[1] === 1'b1) lq_dn1.push_back(cyc - e0);
            if (dn_held[0] === 1'b1) dn_held_seen = 1'b1;
         end
      end
   end

   initial begin
      int want[$];
      int none[$];
      int rem[2];
      bit lvl[2];

      @(posedge clk_50); #1;
      chk_en = 1'b1;
      e0 = cyc;
      to_rel(3);
      reset = 1'b0;
      @(negedge clk_50);
      chk("rst_seq_up", seq_up[0], 1'b0);
      chk("rst_up_held", up_held[0], 1'b0);
      e0 = cyc;
      to_rel(5);

      // clean press held 40 cycles
      e0 = cyc; clear_logs();
      pb_up_n = 1'b0;
      to_rel(6);  @(negedge clk_50);
      chk("held_e6", up_held[0], 1'b0);
      to_rel(7);  @(negedge clk_50);
      chk("held_e7", up_held[0], 1'b1);
      chk("pulse_e7", seq_up[0], 1'b1);
      to_rel(41);
      want = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
      cmp_log("rep_up", lq_up0, want);
      want = '{7};
      cmp_log("one_up", lq_up1, want);
      cmp_log("press_dn", lq_dn0, none);
      pb_up_n = 1'b1;
      to_rel(55);

      // bounce on DOWN: 2-cycle toggles for 20 cycles
      e0 = cyc; clear_logs();
      for (int t = 0; t < 10; t++) begin
         pb_dn_n = (t % 2 == 0) ? 1'b0 : 1'b1;
         to_rel(2 * (t + 1));
      end
      pb_dn_n = 1'b1;
      to_rel(32);
      cmp_log("bounce_dn0", lq_dn0, none);
      cmp_log("bounce_dn1", lq_dn1, none);
      chk("bounce_held", dn_held_seen, 1'b0);

      // simultaneous press, then release UP only
      e0 = cyc; clear_logs();
      pb_up_n = 1'b0; pb_dn_n = 1'b0;
      to_rel(15); @(negedge clk_50);
      chk("sim_up_held", up_held[0], 1'b1);
      chk("sim_dn_held", dn_held[0], 1'b1);
      to_rel(16);
      pb_up_n = 1'b1;
      to_rel(50);
      cmp_log("sim_up", lq_up0, none);
      cmp_log("sim_dn", lq_dn0, none);
      cmp_log("sim_dn1", lq_dn1, none);
      pb_dn_n = 1'b1;
      to_rel(62);

      // reset pulse mid-hold
      e0 = cyc; clear_logs();
      pb_up_n = 1'b0;
      to_rel(15);
      reset = 1'b1;
      to_rel(16);
      reset = 1'b0;
      @(negedge clk_50);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("mrst_up%0d", i),  seq_up[i],  1'b0);
         chk($sformatf("mrst_dn%0d", i),  seq_dn[i],  1'b0);
         chk($sformatf("mrst_uh%0d", i),  up_held[i], 1'b0);
         chk($sformatf("mrst_dh%0d", i),  dn_held[i], 1'b0);
      end
      to_rel(46);
      want = '{7, 23, 33, 36, 39, 42, 45};
      cmp_log("mrst_rep", lq_up0, want);
      want = '{7, 23};
      cmp_log("mrst_one", lq_up1, want);
      pb_up_n = 1'b1;
      to_rel(60);

      // random presses, glitches and occasional resets
      rem[0] = 0; rem[1] = 0;
      lvl[0] = 1'b1; lvl[1] = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk_50); #1;
         for (int k = 0; k < 2; k++) begin
            if (rem[k] == 0) begin
               lvl[k] = 1'($urandom_range(0, 1));
               rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(5, 60));
            end
            rem[k]--;
         end
         pb_up_n = lvl[0];
         pb_dn_n = lvl[1];
         reset   = ($urandom_range(0, 1999) == 0);
      end
      reset = 1'b0;
      pb_up_n = 1'b1; pb_dn_n = 1'b1;
      repeat (20) @(posedge clk_50);
      @(negedge clk_50); #1;
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
